// File: rtl/cnn_ctrl_responder.sv
// cnn_ctrl_responder
//   Accelerator-side responder for the CNN control handshake. The host-level
//   inputs start, same_w and finished_ok are synchronised into the clk domain.
//   A start rising edge launches a weight-load phase and then a convolution run.
//   The weight-load phase is skipped when the host asks to reuse weights and
//   weights are already loaded. When the run completes, finished is raised and
//   held until the host acknowledges with finished_ok.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        host start request (level, async)
//   same_w       reuse previously loaded weights (async)
//   finished_ok  host acknowledge of finished (level, async)
//   conv_done    datapath completion, synchronous to clk
//   finished     run complete, held until acknowledged
//   busy         controller not idle
//   w_load_en    weight write strobe
//   w_addr       weight word address, 0 outside the load phase
//   conv_start   one-cycle datapath launch pulse
module cnn_ctrl_responder #(
    parameter int W_WORDS  = 9,
    parameter int ADDR_W   = 4,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              same_w,
    input  logic              finished_ok,
    input  logic              conv_done,
    output logic              finished,
    output logic              busy,
    output logic              w_load_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              conv_start
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] WAIT_D = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W_WORDS - 1);

    logic [SYNC_STG-1:0] start_sync, same_sync, ok_sync;
    logic                s_start, s_same_w, s_finished_ok;
    logic                start_prev, start_rise;
    logic [2:0]          state;
    logic [ADDR_W-1:0]   w_cnt;
    logic                w_valid;

    assign s_start       = start_sync[SYNC_STG-1];
    assign s_same_w      = same_sync[SYNC_STG-1];
    assign s_finished_ok = ok_sync[SYNC_STG-1];
    assign start_rise    = s_start & ~start_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            same_sync  <= '0;
            ok_sync    <= '0;
        end else begin
            start_sync <= {start_sync[SYNC_STG-2:0], start};
            same_sync  <= {same_sync[SYNC_STG-2:0], same_w};
            ok_sync    <= {ok_sync[SYNC_STG-2:0], finished_ok};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            w_cnt      <= '0;
            w_valid    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            // Edge detector runs in every state so a start held through a
            // run cannot look like a fresh request once back in IDLE.
            start_prev <= s_start;
            case (state)
                IDLE: begin
                    w_cnt <= '0;
                    if (start_rise)
                        state <= (!s_same_w || !w_valid) ? LOAD_W : RUN;
                end
                LOAD_W: begin
                    if (w_cnt == LAST_ADDR) begin
                        w_cnt   <= '0;
                        w_valid <= 1'b1;
                        state   <= RUN;
                    end else begin
                        w_cnt <= w_cnt + ADDR_W'(1);
                    end
                end
                RUN:    state <= WAIT_D;
                WAIT_D: if (conv_done) state <= FIN;
                FIN:    if (s_finished_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded straight from the state register, so they are all
    // zero in IDLE and drop the instant reset is asserted.
    assign busy       = (state != IDLE);
    assign w_load_en  = (state == LOAD_W);
    assign w_addr     = (state == LOAD_W) ? w_cnt : '0;
    assign conv_start = (state == RUN);
    assign finished   = (state == FIN);

endmodule

// File: tb/tb_cnn_ctrl_responder.sv
module tb_cnn_ctrl_responder;

    localparam int W_WORDS = 9;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0, same_w = 1'b0, finished_ok = 1'b0, conv_done = 1'b0;
    logic              finished, busy, w_load_en, conv_start;
    logic [ADDR_W-1:0] w_addr;

    cnn_ctrl_responder #(.W_WORDS(W_WORDS), .ADDR_W(ADDR_W), .SYNC_STG(2)) dut (
        .clk(clk), .reset(reset), .start(start), .same_w(same_w),
        .finished_ok(finished_ok), .conv_done(conv_done), .finished(finished),
        .busy(busy), .w_load_en(w_load_en), .w_addr(w_addr), .conv_start(conv_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Reference model: a run is described by timestamps. A run is accepted at
    // cycle t0 (the synced start rise), loads nload words, launches at
    // t0+nload+1, sees completion at done_c and is acknowledged at fin_end.
    int       cyc_n = 0;
    int       t0 = -1, nload = 0, done_c = -1, fin_end = -1;
    bit       m_wvalid = 0, m_prev = 0;
    bit [2:0] h1 = '0, h2 = '0;   // {ok, same_w, start} driven 1 and 2 cycles ago

    int o_busy, o_wle, o_addr, o_cs, o_fin;
    int n_wle, n_cs, n_fin, cs_cyc;

    typedef struct {
        int n;
        int st, sw, ok, cd;
        int busy, wle, addr0, astep, cs, fin;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic clr_counts();
        n_wle = 0; n_cs = 0; n_fin = 0; cs_cyc = -1;
    endtask

    task automatic model_reset();
        t0 = -1; nload = 0; done_c = -1; fin_end = -1;
        m_wvalid = 0; m_prev = 0; h1 = '0; h2 = '0;
    endtask

    // One clock cycle: check outputs of this cycle, drive inputs, advance model.
    task automatic cyc(input logic st, input logic sw, input logic ok, input logic cd);
        int  c;
        bit  s_st, s_sw, s_ok, act, run_on;
        int  e_busy, e_wle, e_addr, e_cs, e_fin;
        @(posedge clk); #1;
        cyc_n++;
        c = cyc_n;
        s_st = h2[0]; s_sw = h2[1]; s_ok = h2[2];
        act    = (t0 >= 0);
        run_on = act && (c > t0) && (fin_end < 0 || c <= fin_end);
        e_busy = int'(run_on);
        e_wle  = int'(act && nload > 0 && c > t0 && c <= t0 + nload);
        e_addr = (e_wle != 0) ? c - t0 - 1 : 0;
        e_cs   = int'(act && c == t0 + nload + 1);
        e_fin  = int'(run_on && done_c >= 0 && c > done_c);
        o_busy = int'(busy); o_wle = int'(w_load_en); o_addr = int'(w_addr);
        o_cs = int'(conv_start); o_fin = int'(finished);
        chk("busy", o_busy, e_busy);
        chk("w_load_en", o_wle, e_wle);
        chk("w_addr", o_addr, e_addr);
        chk("conv_start", o_cs, e_cs);
        chk("finished", o_fin, e_fin);
        n_wle += o_wle; n_cs += o_cs; n_fin += o_fin;
        if (o_cs != 0) cs_cyc = c;
        start = st; same_w = sw; finished_ok = ok; conv_done = cd;
        // advance model with the synced view of this cycle
        if (act && nload > 0 && c >= t0 + nload) m_wvalid = 1;
        if (act && done_c < 0 && c >= t0 + nload + 2 && cd) done_c = c;
        else if (act && done_c >= 0 && c > done_c && fin_end < 0 && s_ok) fin_end = c;
        if ((t0 < 0 || (fin_end >= 0 && c > fin_end)) && s_st && !m_prev) begin
            t0 = c;
            nload = (!s_sw || !m_wvalid) ? W_WORDS : 0;
            done_c = -1; fin_end = -1;
        end
        m_prev = s_st;
        h2 = h1;
        h1 = {ok, sw, st};
    endtask

    task automatic do_reset(input bit check);
        start = 0; same_w = 0; finished_ok = 0; conv_done = 0;
        #2 reset = 1'b1;
        #1;
        if (check) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_w_load_en", int'(w_load_en), 0);
            chk("rst_w_addr", int'(w_addr), 0);
            chk("rst_conv_start", int'(conv_start), 0);
            chk("rst_finished", int'(finished), 0);
        end
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain(input logic st, input logic sw);
        repeat (12) cyc(st, sw, 1, 1);
        repeat (4) cyc(st, sw, 0, 0);
        chk("drain_idle", o_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1);
    end

    initial begin
        int  d;
        bit  found;
        logic rst_, rsw, rok, rcd;

        //        n  st sw ok cd  busy wle a0 as cs fin
        tbl[0] = '{3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{9, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        tbl[3] = '{4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[6] = '{3, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1};
        tbl[7] = '{3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        // T1: reset state, then a full run driven from the table
        do_reset(1);
        clr_counts();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].st[0], tbl[i].sw[0], tbl[i].ok[0], tbl[i].cd[0]);
                chk("t1_busy", o_busy, tbl[i].busy);
                chk("t1_w_load_en", o_wle, tbl[i].wle);
                chk("t1_w_addr", o_addr, tbl[i].addr0 + k * tbl[i].astep);
                chk("t1_conv_start", o_cs, tbl[i].cs);
                chk("t1_finished", o_fin, tbl[i].fin);
            end
        end
        chk("t1_n_wle", n_wle, W_WORDS);
        chk("t1_n_cs", n_cs, 1);

        // T2a: reuse weights, launch one cycle after the synced rise
        repeat (3) cyc(0, 1, 0, 0);
        clr_counts();
        d = cyc_n + 1;
        repeat (6) cyc(1, 1, 0, 0);
        chk("t2_reuse_n_wle", n_wle, 0);
        chk("t2_reuse_n_cs", n_cs, 1);
        chk("t2_reuse_latency", cs_cyc - d, 3);
        drain(1, 1);

        // T2b: after reset, same_w=1 still forces a full load
        do_reset(0);
        repeat (2) cyc(0, 1, 0, 0);
        clr_counts();
        d = cyc_n + 1;
        repeat (14) cyc(1, 1, 0, 0);
        chk("t2_reload_n_wle", n_wle, W_WORDS);
        chk("t2_reload_latency", cs_cyc - d, W_WORDS + 3);
        drain(1, 1);

        // T3: start held through FIN and IDLE does not retrigger
        repeat (3) cyc(0, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);
        repeat (12) cyc(1, 1, 1, 1);
        clr_counts();
        repeat (15) cyc(1, 1, 0, 0);
        chk("t3_held_n_cs", n_cs, 0);
        chk("t3_held_busy", o_busy, 0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);
        chk("t3_rearm_n_cs", n_cs, 1);

        // T4: acknowledge already high before completion -> one-cycle finished
        clr_counts();
        repeat (4) cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 1);
        repeat (6) cyc(1, 1, 1, 0);
        chk("t4_n_fin", n_fin, 1);
        chk("t4_idle", o_busy, 0);
        repeat (3) cyc(0, 1, 0, 0);

        // T5: reset in the middle of the load phase
        found = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1, 0, 0, 0);
            if (o_wle != 0 && o_addr == 4) begin
                found = 1;
                break;
            end
        end
        chk("t5_reach_addr4", int'(found), 1);
        do_reset(1);
        repeat (2) cyc(0, 1, 0, 0);
        clr_counts();
        repeat (14) cyc(1, 1, 0, 0);
        chk("t5_reload_n_wle", n_wle, W_WORDS);
        drain(0, 1);

        // T6: stray conv_done in IDLE/LOAD_W, start toggled in WAIT_D
        clr_counts();
        repeat (4) cyc(0, 0, 0, 1);
        repeat (8) cyc(1, 0, 0, 1);
        repeat (6) cyc(1, 0, 0, 0);
        chk("t6_no_fin", n_fin, 0);
        chk("t6_waiting", o_busy, 1);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("t6_one_cs", n_cs, 1);
        chk("t6_still_no_fin", n_fin, 0);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0);
        chk("t6_done_idle", o_busy, 0);
        chk("t6_fin_seen", int'(n_fin > 0), 1);

        // Random traffic against the model, with occasional resets
        rst_ = 0; rsw = 0; rok = 0; rcd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rst_ = ~rst_;
            if ($urandom_range(0, 15) == 0) rsw = ~rsw;
            if ($urandom_range(0, 5) == 0) rok = ~rok;
            rcd = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(0);
            cyc(rst_, rsw, rok, rcd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
